pll_reconfig_scheduler: RTL and testbench

Shares the runtime-reprogrammable PLL clock generator between several requesters (host register file, sample-rate table, etc.). It arbitrates requests round-robin, range-checks the divider triplet and drives the generator's O/D/M/start handshake. It then waits for programming to complete and for a stable lock, and reports a per-request completion status. It sits in the generator's configuration clock domain, directly in front of the clock generator.

---
 rtl/pll_sched_pkg.sv | 41 ++++
 rtl/pll_sched_rr_arbiter.sv | 40 ++++
 rtl/pll_reconfig_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_pll_reconfig_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sched_pkg.sv
// Shared state encoding, completion codes and divider limits for the PLL
// reconfiguration scheduler.
package pll_sched_pkg;

    localparam int ID_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_START,
        ST_WAIT_ACK,
        ST_WAIT_DONE,
        ST_WAIT_LOCK,
        ST_RETRY,
        ST_REPORT
    } sched_state_t;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_PARAM    = 2'd1;
    localparam logic [1:0] ERR_ACK_TMO  = 2'd2;
    localparam logic [1:0] ERR_LOCK_TMO = 2'd3;

    localparam logic [7:0] O_MIN = 8'd1;
    localparam logic [3:0] D_MIN = 4'd1;
    localparam logic [3:0] D_MAX = 4'd10;
    localparam logic [6:0] M_MIN = 7'd2;
    localparam logic [6:0] M_MAX = 7'd64;

    // Generator's own reset triplet, so both sides agree after rst.
    localparam logic [7:0] GEN_O_RST = 8'd2;
    localparam logic [3:0] GEN_D_RST = 4'd4;
    localparam logic [6:0] GEN_M_RST = 7'd2;

    function automatic logic params_ok(input logic [7:0] o_div,
                                       input logic [3:0] d_div,
                                       input logic [6:0] m_mul);
        return (o_div >= O_MIN) && (d_div >= D_MIN) && (d_div <= D_MAX) &&
               (m_mul >= M_MIN) && (m_mul <= M_MAX);
    endfunction

endpackage

// File: rtl/pll_sched_rr_arbiter.sv
// Round-robin pick: first requester at or after i_rr_ptr, wrapping to the
// lowest index below it.
module pll_sched_rr_arbiter
    import pll_sched_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic w_found;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        // First pass covers ptr..NUM_REQ-1, second pass the wrapped part.
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req_valid[j] && (j >= int'(i_rr_ptr))) begin
                o_grant[j] = 1'b1;
                o_idx      = ID_W'(j);
                w_found    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req_valid[j]) begin
                o_grant[j] = 1'b1;
                o_idx      = ID_W'(j);
                w_found    = 1'b1;
            end
        end
    end

    assign o_any = w_found;

endmodule

// File: rtl/pll_reconfig_scheduler.sv
// Arbitrates PLL reprogramming requests, drives the generator handshake and
// waits for stable lock. Retry on lock timeout is built when PLL_SCHED_RETRY_EN is defined.
module pll_reconfig_scheduler
    import pll_sched_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int ACK_TIMEOUT  = 255,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_STABLE  = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [8*NUM_REQ-1:0]   i_req_O,
    input  logic [4*NUM_REQ-1:0]   i_req_D,
    input  logic [7*NUM_REQ-1:0]   i_req_M,
    output logic [NUM_REQ-1:0]     o_req_ack,
    output logic [7:0]             o_gen_O,
    output logic [3:0]             o_gen_D,
    output logic [6:0]             o_gen_M,
    output logic                   o_gen_start,
    input  logic                   i_gen_program_done,
    input  logic                   i_gen_locked,
    output logic                   o_busy,
    output logic                   o_done_valid,
    output logic [1:0]             o_done_id,
    output logic [1:0]             o_done_err
);

    localparam int STAB_W = (LOCK_STABLE < 2) ? 1 : $clog2(LOCK_STABLE + 1);

    sched_state_t        r_state;
    sched_state_t        w_next_state;
    logic [1:0]          w_err;
    logic                w_retry_ok;
    logic                w_grant_now;

    logic [NUM_REQ-1:0]  w_arb_grant;
    logic [ID_W-1:0]     w_arb_idx;
    logic                w_arb_any;
    logic [7:0]          w_sel_O;
    logic [3:0]          w_sel_D;
    logic [6:0]          w_sel_M;

    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_cur_id;
    logic [NUM_REQ-1:0]  r_req_ack;
    logic [7:0]          r_gen_O;
    logic [3:0]          r_gen_D;
    logic [6:0]          r_gen_M;
    logic [1:0]          r_done_id;
    logic [1:0]          r_done_err;
    logic                r_lock_meta;
    logic                r_lock_sync;
    logic [7:0]          r_ack_cnt;
    logic [15:0]         r_lock_tmo;
    logic [STAB_W-1:0]   r_stab_cnt;

    pll_sched_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req_valid (i_req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_idx       (w_arb_idx),
        .o_any       (w_arb_any)
    );

    assign w_grant_now = (r_state == ST_IDLE) && w_arb_any;

    always_comb begin
        w_sel_O = '0;
        w_sel_D = '0;
        w_sel_M = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_arb_grant[j]) begin
                w_sel_O = i_req_O[8*j +: 8];
                w_sel_D = i_req_D[4*j +: 4];
                w_sel_M = i_req_M[7*j +: 7];
            end
        end
    end

`ifdef PLL_SCHED_RETRY_EN
    localparam int RTRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RTRY_W-1:0] r_retry_cnt;

    assign w_retry_ok = (r_retry_cnt < RTRY_W'(MAX_RETRY));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_retry_cnt <= '0;
        end else if (w_grant_now) begin
            r_retry_cnt <= '0;
        end else if ((r_state == ST_RETRY) && w_retry_ok) begin
            r_retry_cnt <= r_retry_cnt + 1'b1;
        end
    end
`else
    // MAX_RETRY has no effect when retry is not built.
    logic w_unused_max_retry;
    assign w_unused_max_retry = (MAX_RETRY != 0);
    assign w_retry_ok = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        w_err        = ERR_OK;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) w_next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (params_ok(r_gen_O, r_gen_D, r_gen_M)) begin
                    w_next_state = ST_START;
                end else begin
                    w_next_state = ST_REPORT;
                    w_err        = ERR_PARAM;
                end
            end
            ST_START: begin
                w_next_state = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!i_gen_program_done) begin
                    w_next_state = ST_WAIT_DONE;
                end else if (r_ack_cnt <= 8'd1) begin
                    w_next_state = ST_REPORT;
                    w_err        = ERR_ACK_TMO;
                end
            end
            ST_WAIT_DONE: begin
                if (i_gen_program_done) w_next_state = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // A lock completing on the timeout cycle still counts as success.
                if (r_lock_sync && (r_stab_cnt <= STAB_W'(1))) begin
                    w_next_state = ST_REPORT;
                    w_err        = ERR_OK;
                end else if (r_lock_tmo <= 16'd1) begin
                    w_next_state = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (w_retry_ok) begin
                    w_next_state = ST_START;
                end else begin
                    w_next_state = ST_REPORT;
                    w_err        = ERR_LOCK_TMO;
                end
            end
            ST_REPORT: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_cur_id    <= '0;
            r_req_ack   <= '0;
            r_gen_O     <= GEN_O_RST;
            r_gen_D     <= GEN_D_RST;
            r_gen_M     <= GEN_M_RST;
            r_done_id   <= '0;
            r_done_err  <= '0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_ack_cnt   <= '0;
            r_lock_tmo  <= '0;
            r_stab_cnt  <= '0;
        end else begin
            r_state     <= w_next_state;
            r_lock_meta <= i_gen_locked;
            r_lock_sync <= r_lock_meta;
            r_req_ack   <= '0;

            if (w_grant_now) begin
                r_req_ack <= w_arb_grant;
                r_cur_id  <= w_arb_idx;
                r_rr_ptr  <= (w_arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_arb_idx + 1'b1;
                r_gen_O   <= w_sel_O;
                r_gen_D   <= w_sel_D;
                r_gen_M   <= w_sel_M;
            end

            if (w_next_state == ST_REPORT) begin
                r_done_id  <= r_cur_id;
                r_done_err <= w_err;
            end

            case (r_state)
                ST_START: begin
                    r_ack_cnt <= 8'(ACK_TIMEOUT);
                end
                ST_WAIT_ACK: begin
                    if (r_ack_cnt != 8'd0) r_ack_cnt <= r_ack_cnt - 8'd1;
                end
                ST_WAIT_DONE: begin
                    r_lock_tmo <= 16'(LOCK_TIMEOUT);
                    r_stab_cnt <= STAB_W'(LOCK_STABLE);
                end
                ST_WAIT_LOCK: begin
                    if (r_lock_tmo != 16'd0) r_lock_tmo <= r_lock_tmo - 16'd1;
                    if (!r_lock_sync) begin
                        r_stab_cnt <= STAB_W'(LOCK_STABLE);
                    end else if (r_stab_cnt != '0) begin
                        r_stab_cnt <= r_stab_cnt - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_req_ack    = r_req_ack;
    assign o_gen_O      = r_gen_O;
    assign o_gen_D      = r_gen_D;
    assign o_gen_M      = r_gen_M;
    assign o_gen_start  = (r_state == ST_START) || (r_state == ST_WAIT_ACK);
    assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_REPORT);
    assign o_done_valid = (r_state == ST_REPORT);
    assign o_done_id    = r_done_id;
    assign o_done_err   = r_done_err;

endmodule

// File: tb/tb_pll_reconfig_scheduler.sv
// Scoreboard bench for pll_reconfig_scheduler with a behavioural clock
// generator model (ack delay, program time, lock behaviour selectable).
module tb_pll_reconfig_scheduler;

    typedef struct {
        logic [1:0] id;
        logic [1:0] err;
    } exp_t;

`ifdef PLL_SCHED_RETRY_EN
    localparam int EXP_ATTEMPTS = 4;
`else
    localparam int EXP_ATTEMPTS = 1;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_O;
    logic [7:0]  req_D;
    logic [13:0] req_M;
    logic [1:0]  req_ack;
    logic [7:0]  gen_O;
    logic [3:0]  gen_D;
    logic [6:0]  gen_M;
    logic        gen_start;
    logic        gen_program_done;
    logic        gen_locked;
    logic        busy;
    logic        done_valid;
    logic [1:0]  done_id;
    logic [1:0]  done_err;

    int   total;
    int   bad;
    exp_t sb_q[$];
    int   n_done;
    int   n_starts;
    int   ack_cnt[2];
    int   start_run;
    int   last_run;
    int   cyc;
    int   done_cyc;
    int   lock_set_cyc;
    logic prev_start;

    int   gst;
    int   gcnt;
    logic no_ack;
    int   lock_mode;

    pll_reconfig_scheduler #(
        .NUM_REQ      (2),
        .ACK_TIMEOUT  (255),
        .LOCK_TIMEOUT (200),
        .LOCK_STABLE  (16),
        .MAX_RETRY    (3)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_req_valid        (req_valid),
        .i_req_O            (req_O),
        .i_req_D            (req_D),
        .i_req_M            (req_M),
        .o_req_ack          (req_ack),
        .o_gen_O            (gen_O),
        .o_gen_D            (gen_D),
        .o_gen_M            (gen_M),
        .o_gen_start        (gen_start),
        .i_gen_program_done (gen_program_done),
        .i_gen_locked       (gen_locked),
        .o_busy             (busy),
        .o_done_valid       (done_valid),
        .o_done_id          (done_id),
        .o_done_err         (done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Generator model: accepts start after 3 cycles, programs for 50 cycles,
    // then locks after 10 cycles (mode 0), toggles lock every 8 (mode 1) or never locks (mode 2).
    initial begin
        gen_program_done = 1'b1;
        gen_locked       = 1'b0;
        gst  = 0;
        gcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                gen_program_done = 1'b1;
                gen_locked       = 1'b0;
                gst  = 0;
                gcnt = 0;
            end else begin
                if (gst == 2 && gen_start) begin
                    gst  = 0;
                    gcnt = 0;
                end
                case (gst)
                    0: begin
                        if (gen_start && !no_ack) begin
                            gcnt++;
                            if (gcnt >= 3) begin
                                gen_program_done = 1'b0;
                                gen_locked       = 1'b0;
                                gst  = 1;
                                gcnt = 0;
                            end
                        end else begin
                            gcnt = 0;
                        end
                    end
                    1: begin
                        gcnt++;
                        if (gcnt >= 50) begin
                            gen_program_done = 1'b1;
                            gst  = 2;
                            gcnt = 0;
                        end
                    end
                    default: begin
                        gcnt++;
                        if (lock_mode == 1) begin
                            if (gcnt % 8 == 0) gen_locked = !gen_locked;
                        end else if (lock_mode == 0 && gcnt == 10) begin
                            gen_locked   = 1'b1;
                            lock_set_cyc = cyc;
                        end
                    end
                endcase
            end
        end
    end

    // Output monitor: scoreboard pop on completion, ack and start bookkeeping.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (done_valid) begin
                chk("sb_nonempty", sb_q.size() != 0, 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk("done_id", done_id, e.id);
                    chk("done_err", done_err, e.err);
                    chk("busy_at_done", busy, 0);
                end
                n_done++;
                done_cyc = cyc;
            end
            if (req_ack != 2'b00) chk("ack_onehot", $countones(req_ack), 1);
            if (req_ack[0]) ack_cnt[0]++;
            if (req_ack[1]) ack_cnt[1]++;
        end
        if (gen_start && !prev_start) n_starts++;
        if (gen_start) start_run++;
        else if (prev_start) begin
            last_run  = start_run;
            start_run = 0;
        end
        prev_start = gen_start;
    end

    task automatic check_reset_outputs();
        chk("rst_req_ack", req_ack, 0);
        chk("rst_gen_O", gen_O, 2);
        chk("rst_gen_D", gen_D, 4);
        chk("rst_gen_M", gen_M, 2);
        chk("rst_gen_start", gen_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_valid", done_valid, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_done_err", done_err, 0);
    endtask

    task automatic issue(input int id, input logic [7:0] o, input logic [3:0] d,
                         input logic [6:0] m, input logic [1:0] err);
        exp_t e;
        logic got;
        req_O[id*8 +: 8] = o;
        req_D[id*4 +: 4] = d;
        req_M[id*7 +: 7] = m;
        e.id  = 2'(id);
        e.err = err;
        sb_q.push_back(e);
        req_valid[id] = 1'b1;
        got = 1'b0;
        for (int w = 0; w < 400 && !got; w++) begin
            @(negedge clk);
            if (req_ack[id]) got = 1'b1;
        end
        chk("ack_seen", got, 1);
        req_valid[id] = 1'b0;
        if (got) begin
            chk("gen_O", gen_O, o);
            chk("gen_D", gen_D, d);
            chk("gen_M", gen_M, m);
            chk("busy_at_ack", busy, 1);
            chk("start_pre", gen_start, 0);
            @(negedge clk);
            chk("start_lat", gen_start, (err == 2'd1) ? 0 : 1);
        end
    endtask

    task automatic wait_done(input int budget);
        int  n0;
        logic seen;
        n0   = n_done;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (n_done != n0) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int a0;
        int a1;
        int seen;
        int nd0;
        exp_t e;
        logic reached;

        total = 0; bad = 0; n_done = 0; n_starts = 0;
        ack_cnt[0] = 0; ack_cnt[1] = 0;
        start_run = 0; last_run = 0; prev_start = 1'b0;
        done_cyc = 0; lock_set_cyc = 0;
        no_ack = 1'b0; lock_mode = 0;
        rst = 1'b1;
        req_valid = '0; req_O = '0; req_D = '0; req_M = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        // Single request with normal lock.
        s0 = n_starts;
        issue(0, 8'd25, 4'd4, 7'd42, 2'd0);
        wait_done(500);
        chk("single_starts", n_starts - s0, 1);
        chk("start_hold_3plus", last_run >= 3, 1);
        chk("lock_stable_lat", done_cyc - lock_set_cyc, 18);

        // Out-of-range parameters never start the generator.
        s0 = n_starts;
        issue(1, 8'd25, 4'd4, 7'd1, 2'd1);
        wait_done(50);
        issue(0, 8'd25, 4'd11, 7'd42, 2'd1);
        wait_done(50);
        issue(1, 8'd0, 4'd4, 7'd42, 2'd1);
        wait_done(50);
        chk("bad_no_start", n_starts - s0, 0);

        // Generator never accepts start.
        no_ack = 1'b1;
        issue(0, 8'd8, 4'd2, 7'd20, 2'd2);
        wait_done(600);
        chk("ack_tmo_start_low", gen_start, 0);
        chk("ack_tmo_len", (last_run >= 255) && (last_run <= 257), 1);
        no_ack = 1'b0;

        // Lock glitching every 8 cycles never reaches a stable run.
        lock_mode = 1;
        s0 = n_starts;
        issue(1, 8'd12, 4'd3, 7'd30, 2'd3);
        wait_done(3000);
        chk("lock_attempts", n_starts - s0, EXP_ATTEMPTS);
        lock_mode = 0;

        // Both requesters held: rr_ptr is 0 here, so grants go 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            e.id  = 2'(k % 2);
            e.err = 2'd0;
            sb_q.push_back(e);
        end
        a0 = ack_cnt[0];
        a1 = ack_cnt[1];
        req_O = {8'd5, 8'd10};
        req_D = {4'd10, 4'd2};
        req_M = {7'd64, 7'd40};
        req_valid = 2'b11;
        seen = 0;
        for (int i = 0; i < 3000 && seen < 4; i++) begin
            @(negedge clk);
            if (done_valid) seen++;
        end
        req_valid = 2'b00;
        @(negedge clk);
        chk("rr_done4", seen, 4);
        chk("rr_ack0", ack_cnt[0] - a0, 2);
        chk("rr_ack1", ack_cnt[1] - a1, 2);
        repeat (3) @(negedge clk);
        chk("rr_idle_after", busy, 0);

        // Reset while waiting for a lock that never comes.
        lock_mode = 2;
        issue(0, 8'd30, 4'd3, 7'd50, 2'd0);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (gst == 2) reached = 1'b1;
        end
        chk("reach_wait_lock", reached, 1);
        repeat (30) @(negedge clk);
        chk("busy_pre_rst", busy, 1);
        nd0 = n_done;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        void'(sb_q.pop_front());
        @(negedge clk);
        rst = 1'b0;
        lock_mode = 0;
        repeat (20) @(negedge clk);
        chk("no_done_after_abort", n_done - nd0, 0);
        check_reset_outputs();

        // Served normally after reset; lower range limits accepted.
        issue(1, 8'd1, 4'd1, 7'd2, 2'd0);
        wait_done(500);

        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
